// File: rtl/irb_dw_addr_gen.sv
// Depthwise-stage address sequencer: walks ch/oy/ox/ky/kx over the FMINT tile RAM
// and streams one registered tap beat per transfer under a valid/ready handshake.
module irb_dw_addr_gen #(
  parameter int unsigned NKX     = 3,
  parameter int unsigned NKY     = 3,
  parameter int unsigned TIX_MAX = 16,
  parameter int unsigned TIY_MAX = 16,
  parameter int unsigned TOX_MAX = 14,
  parameter int unsigned TOY_MAX = 14,
  parameter int unsigned NPAR    = 8,
  parameter int unsigned IN_AW   = $clog2(TIX_MAX*TIY_MAX*NPAR),
  parameter int unsigned OUT_AW  = $clog2(TOX_MAX*TOY_MAX*NPAR),
  localparam int unsigned TOXW   = $clog2(TOX_MAX+1),
  localparam int unsigned TOYW   = $clog2(TOY_MAX+1),
  localparam int unsigned NCHW   = $clog2(NPAR+1),
  localparam int unsigned KW     = (NKX*NKY > 1) ? $clog2(NKX*NKY) : 1,
  localparam int unsigned CHW    = (NPAR > 1) ? $clog2(NPAR) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TOXW-1:0]   cfg_tox,
  input  logic [TOYW-1:0]   cfg_toy,
  input  logic              cfg_stride,
  input  logic [NCHW-1:0]   cfg_nch,
  input  logic              abort,
  output logic              tap_valid,
  input  logic              tap_ready,
  output logic [IN_AW-1:0]  rd_addr,
  output logic [KW-1:0]     k_idx,
  output logic [CHW-1:0]    ch,
  output logic [OUT_AW-1:0] out_addr,
  output logic              first_tap,
  output logic              last_tap,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int unsigned KXW = (NKX > 1) ? $clog2(NKX) : 1;
  localparam int unsigned KYW = (NKY > 1) ? $clog2(NKY) : 1;
  localparam int unsigned OXW = (TOX_MAX > 1) ? $clog2(TOX_MAX) : 1;
  localparam int unsigned OYW = (TOY_MAX > 1) ? $clog2(TOY_MAX) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t r_state, w_state_nxt;

  logic [KXW-1:0]  r_kx, w_kx_nxt;
  logic [KYW-1:0]  r_ky, w_ky_nxt;
  logic [OXW-1:0]  r_ox, w_ox_nxt;
  logic [OYW-1:0]  r_oy, w_oy_nxt;
  logic [CHW-1:0]  r_ch, w_ch_nxt;

  logic [TOXW-1:0] r_tox, w_tox_nxt;
  logic [TOYW-1:0] r_toy, w_toy_nxt;
  logic [NCHW-1:0] r_nch, w_nch_nxt;
  logic            r_stride, w_stride_nxt;

  logic              r_tap_valid, w_valid_nxt;
  logic [IN_AW-1:0]  r_rd_addr, w_rd_nxt;
  logic [KW-1:0]     r_k_idx, w_k_nxt;
  logic [CHW-1:0]    r_ch_o, w_ch_o_nxt;
  logic [OUT_AW-1:0] r_out_addr, w_out_nxt;
  logic              r_first, w_first_nxt;
  logic              r_last, w_last_nxt;
  logic              r_busy, r_done, r_cfg_err;
  logic              w_done_nxt, w_cfg_err_nxt;

  logic        w_cfg_ok, w_xfer, w_last_beat;
  logic [31:0] w_cfg_step, w_step, w_k_full;

  // Window fit is checked at 32 bits so oversized tiles cannot wrap into a pass.
  always_comb begin
    w_cfg_step = cfg_stride ? 32'd2 : 32'd1;
    w_cfg_ok   = (cfg_tox != '0) && (cfg_toy != '0) && (cfg_nch != '0)
              && (32'(cfg_nch) <= NPAR)
              && (32'(cfg_tox) <= TOX_MAX) && (32'(cfg_toy) <= TOY_MAX)
              && ((32'(cfg_tox) - 32'd1) * w_cfg_step + NKX <= TIX_MAX)
              && ((32'(cfg_toy) - 32'd1) * w_cfg_step + NKY <= TIY_MAX);
  end

  assign w_xfer      = r_tap_valid && tap_ready;
  assign w_last_beat = (32'(r_kx) == NKX - 1) && (32'(r_ky) == NKY - 1)
                    && (32'(r_ox) + 32'd1 == 32'(r_tox))
                    && (32'(r_oy) + 32'd1 == 32'(r_toy))
                    && (32'(r_ch) + 32'd1 == 32'(r_nch));

  always_comb begin
    w_state_nxt   = r_state;
    w_kx_nxt      = r_kx;
    w_ky_nxt      = r_ky;
    w_ox_nxt      = r_ox;
    w_oy_nxt      = r_oy;
    w_ch_nxt      = r_ch;
    w_tox_nxt     = r_tox;
    w_toy_nxt     = r_toy;
    w_nch_nxt     = r_nch;
    w_stride_nxt  = r_stride;
    w_valid_nxt   = r_tap_valid;
    w_done_nxt    = 1'b0;
    w_cfg_err_nxt = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          if (w_cfg_ok) begin
            w_state_nxt  = ST_RUN;
            w_valid_nxt  = 1'b1;
            w_tox_nxt    = cfg_tox;
            w_toy_nxt    = cfg_toy;
            w_nch_nxt    = cfg_nch;
            w_stride_nxt = cfg_stride;
            w_kx_nxt     = '0;
            w_ky_nxt     = '0;
            w_ox_nxt     = '0;
            w_oy_nxt     = '0;
            w_ch_nxt     = '0;
          end else begin
            w_cfg_err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (abort || (w_xfer && w_last_beat)) begin
          w_state_nxt = abort ? ST_IDLE : ST_DONE;
          w_done_nxt  = !abort;
          w_valid_nxt = 1'b0;
          w_kx_nxt    = '0;
          w_ky_nxt    = '0;
          w_ox_nxt    = '0;
          w_oy_nxt    = '0;
          w_ch_nxt    = '0;
        end else if (w_xfer) begin
          if (32'(r_kx) != NKX - 1) begin
            w_kx_nxt = r_kx + KXW'(1);
          end else begin
            w_kx_nxt = '0;
            if (32'(r_ky) != NKY - 1) begin
              w_ky_nxt = r_ky + KYW'(1);
            end else begin
              w_ky_nxt = '0;
              if (32'(r_ox) + 32'd1 != 32'(r_tox)) begin
                w_ox_nxt = r_ox + OXW'(1);
              end else begin
                w_ox_nxt = '0;
                if (32'(r_oy) + 32'd1 != 32'(r_toy)) begin
                  w_oy_nxt = r_oy + OYW'(1);
                end else begin
                  w_oy_nxt = '0;
                  w_ch_nxt = r_ch + CHW'(1);
                end
              end
            end
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Beat fields are derived from next-state counters so every output is a flop;
  // while stalled the counters hold, so the recomputed beat is identical.
  always_comb begin
    w_step      = w_stride_nxt ? 32'd2 : 32'd1;
    w_k_full    = 32'(w_ky_nxt) * NKX + 32'(w_kx_nxt);
    w_rd_nxt    = '0;
    w_k_nxt     = '0;
    w_ch_o_nxt  = '0;
    w_out_nxt   = '0;
    w_first_nxt = 1'b0;
    w_last_nxt  = 1'b0;
    if (w_valid_nxt) begin
      w_rd_nxt    = IN_AW'(32'(w_ch_nxt) * TIX_MAX * TIY_MAX
                    + (32'(w_oy_nxt) * w_step + 32'(w_ky_nxt)) * TIX_MAX
                    + 32'(w_ox_nxt) * w_step + 32'(w_kx_nxt));
      w_out_nxt   = OUT_AW'(32'(w_ch_nxt) * TOX_MAX * TOY_MAX
                    + 32'(w_oy_nxt) * TOX_MAX + 32'(w_ox_nxt));
      w_k_nxt     = KW'(w_k_full);
      w_ch_o_nxt  = w_ch_nxt;
      w_first_nxt = (w_k_full == 32'd0);
      w_last_nxt  = (w_k_full == NKX * NKY - 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kx        <= '0;
      r_ky        <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
      r_ch        <= '0;
      r_tox       <= '0;
      r_toy       <= '0;
      r_nch       <= '0;
      r_stride    <= 1'b0;
      r_tap_valid <= 1'b0;
      r_rd_addr   <= '0;
      r_k_idx     <= '0;
      r_ch_o      <= '0;
      r_out_addr  <= '0;
      r_first     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_kx        <= w_kx_nxt;
      r_ky        <= w_ky_nxt;
      r_ox        <= w_ox_nxt;
      r_oy        <= w_oy_nxt;
      r_ch        <= w_ch_nxt;
      r_tox       <= w_tox_nxt;
      r_toy       <= w_toy_nxt;
      r_nch       <= w_nch_nxt;
      r_stride    <= w_stride_nxt;
      r_tap_valid <= w_valid_nxt;
      r_rd_addr   <= w_rd_nxt;
      r_k_idx     <= w_k_nxt;
      r_ch_o      <= w_ch_o_nxt;
      r_out_addr  <= w_out_nxt;
      r_first     <= w_first_nxt;
      r_last      <= w_last_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= w_done_nxt;
      r_cfg_err   <= w_cfg_err_nxt;
    end
  end

  assign tap_valid = r_tap_valid;
  assign rd_addr   = r_rd_addr;
  assign k_idx     = r_k_idx;
  assign ch        = r_ch_o;
  assign out_addr  = r_out_addr;
  assign first_tap = r_first;
  assign last_tap  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_irb_dw_addr_gen.sv
// Directed bench for irb_dw_addr_gen: a loop-nest reference model fills a scoreboard
// of expected beats, which are popped and compared on every handshake transfer.
module tb_irb_dw_addr_gen;

  logic        clk, rst, start, cfg_stride, abort, tap_ready;
  logic [3:0]  cfg_tox, cfg_toy, cfg_nch;
  logic        tap_valid, first_tap, last_tap, busy, done, cfg_err;
  logic [10:0] rd_addr, out_addr;
  logic [3:0]  k_idx;
  logic [2:0]  ch;

  typedef struct packed {
    logic [10:0] rd;
    logic [3:0]  k;
    logic [2:0]  c;
    logic [10:0] out;
    logic        first;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  irb_dw_addr_gen #(.NKX(3), .NKY(3), .TIX_MAX(16), .TIY_MAX(16),
                    .TOX_MAX(14), .TOY_MAX(14), .NPAR(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_tox(cfg_tox), .cfg_toy(cfg_toy), .cfg_stride(cfg_stride), .cfg_nch(cfg_nch),
    .abort(abort), .tap_valid(tap_valid), .tap_ready(tap_ready),
    .rd_addr(rd_addr), .k_idx(k_idx), .ch(ch), .out_addr(out_addr),
    .first_tap(first_tap), .last_tap(last_tap), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_seq(input int tox, input int toy, input int s, input int nch);
    beat_t b;
    for (int c = 0; c < nch; c++)
      for (int oy = 0; oy < toy; oy++)
        for (int ox = 0; ox < tox; ox++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
              b.rd    = 11'(c*256 + (oy*s + ky)*16 + ox*s + kx);
              b.out   = 11'(c*196 + oy*14 + ox);
              b.k     = 4'(ky*3 + kx);
              b.c     = 3'(c);
              b.first = (ky == 0 && kx == 0);
              b.last  = (ky == 2 && kx == 2);
              sb.push_back(b);
            end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the start edge.
  task automatic do_start(input int tox, input int toy, input int s, input int nch, input bit ok);
    cfg_tox = 4'(tox); cfg_toy = 4'(toy); cfg_stride = (s == 2); cfg_nch = 4'(nch);
    start = 1'b1;
    if (ok) push_seq(tox, toy, s, nch);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    if (ok) begin
      check("start_latency", {tap_valid, busy, cfg_err}, 3'b110);
    end else begin
      check("cfg_err_pulse", {tap_valid, busy, cfg_err}, 3'b001);
      @(posedge clk); @(negedge clk);
      check("cfg_err_clear", {busy, cfg_err}, 2'b00);
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: 5-cycle stall mid-kernel.
  task automatic run_beats(input int mode, input int abort_at, input bit poke);
    int beat = 0;
    int cyc = 0;
    int stall_cnt = 0;
    bit held = 1'b0;
    bit aborted = 1'b0;
    beat_t got, saved, expb;
    saved = '0;
    while (sb.size() > 0 && cyc < 3000) begin
      case (mode)
        1: tap_ready = 1'($urandom_range(0, 1));
        2: if (beat == 4 && stall_cnt < 5) begin tap_ready = 1'b0; stall_cnt++; end
           else tap_ready = 1'b1;
        default: tap_ready = 1'b1;
      endcase
      start = poke && (beat == 5);
      if (start) begin cfg_tox = 4'd1; cfg_toy = 4'd1; cfg_stride = 1'b0; cfg_nch = 4'd3; end
      abort = (beat == abort_at) && tap_valid;
      got = {rd_addr, k_idx, ch, out_addr, first_tap, last_tap};
      if (held) check("stall_hold", {tap_valid, got}, {1'b1, saved});
      if (tap_valid && tap_ready) begin
        expb = sb.pop_front();
        check($sformatf("beat%0d", beat), got, expb);
        beat++;
        held = 1'b0;
        if (abort) begin aborted = 1'b1; sb.delete(); end
      end else begin
        held  = tap_valid;
        saved = got;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    start = 1'b0; abort = 1'b0; tap_ready = 1'b1;
    if (sb.size() > 0) begin
      check("timeout_beats_left", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    if (aborted) begin
      check("abort_to_idle", {tap_valid, busy, done}, 3'b000);
    end else begin
      check("done_pulse", {tap_valid, busy, done}, 3'b011);
      @(posedge clk); @(negedge clk);
      check("done_clear", {tap_valid, busy, done}, 3'b000);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; tap_ready = 1'b0;
    cfg_tox = '0; cfg_toy = '0; cfg_stride = 1'b0; cfg_nch = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {tap_valid, rd_addr, k_idx, ch, out_addr, first_tap,
                            last_tap, busy, done, cfg_err}, '0);
    rst = 1'b0;
    @(negedge clk);

    do_start(2, 2, 1, 1, 1'b1); run_beats(0, -1, 1'b0);   // stride 1, 36 beats
    do_start(2, 1, 2, 2, 1'b1); run_beats(0, -1, 1'b0);   // stride 2, two channels
    do_start(2, 2, 1, 1, 1'b1); run_beats(1, -1, 1'b0);   // random backpressure
    do_start(2, 1, 2, 2, 1'b1); run_beats(2, -1, 1'b1);   // long stall + start while busy

    do_start(15, 2, 1, 1, 1'b0);
    do_start(2, 2, 1, 0, 1'b0);
    do_start(2, 2, 1, 9, 1'b0);
    do_start(2, 8, 2, 1, 1'b0);

    do_start(14, 1, 1, 1, 1'b1); run_beats(0, -1, 1'b0);  // widest tile that fits
    do_start(1, 1, 2, 8, 1'b1);  run_beats(0, -1, 1'b0);  // all channels

    do_start(2, 2, 1, 1, 1'b1); run_beats(0, 10, 1'b0);
    do_start(2, 2, 1, 1, 1'b1); run_beats(0, 35, 1'b0);
    do_start(2, 2, 1, 1, 1'b1); run_beats(0, -1, 1'b0);

    cfg_tox = 4'd2; cfg_toy = 4'd2; cfg_stride = 1'b0; cfg_nch = 4'd1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", {tap_valid, busy, cfg_err}, 3'b000);

    do_start(2, 2, 1, 1, 1'b1);
    tap_ready = 1'b1;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_reset_mid_run", {tap_valid, rd_addr, k_idx, ch, out_addr, first_tap,
                                     last_tap, busy, done, cfg_err}, '0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_after_reset", {tap_valid, busy, done}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
